// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the multiply/divide unit
// Contents: FSM state enum, RISC-V M-extension funct3 codes, and the
// iteration-counter width helper.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // The counter must be able to hold DATA_W itself.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M-style multiply/divide unit
// Ports:
//   clk, reset (async, active-low)
//   start, funct3, op_a, op_b : request, sampled only in IDLE
//   flush                     : synchronous abort, wins over start
//   busy                      : high in every state except IDLE
//   done                      : one-cycle pulse, result valid in that cycle
//   result                    : registered result, held until the next done
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int CW = cnt_width(DATA_W);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DATA_W - 1);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [DATA_W-1:0]   ZERO     = '0;
  localparam logic [2*DATA_W-1:0] ZERO2    = '0;
  localparam logic [DATA_W-1:0]   MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              r_state, w_next;
  logic [2:0]          r_funct3;
  logic                r_neg_res;   // negate product / quotient
  logic                r_neg_rem;   // remainder follows the dividend sign
  logic [DATA_W-1:0]   r_addend;    // multiplicand (MUL*) or divisor (DIV*)
  logic [2*DATA_W-1:0] r_acc;       // shared shift register {hi, lo}
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_result;

  // Request decode on the raw inputs
  logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic              w_div_zero, w_ovf, w_fast;
  logic [DATA_W-1:0] w_mag_a, w_mag_b, w_fast_result;

  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign w_b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_a_neg    = w_a_signed & op_a[DATA_W-1];
  assign w_b_neg    = w_b_signed & op_b[DATA_W-1];
  assign w_mag_a    = w_a_neg ? (ZERO - op_a) : op_a;
  assign w_mag_b    = w_b_neg ? (ZERO - op_b) : op_b;
  assign w_div_zero = w_is_div && (op_b == ZERO);
  assign w_ovf      = w_is_div && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
  assign w_fast     = w_div_zero || w_ovf;
  // funct3[1] selects remainder within the divide group
  assign w_fast_result = w_div_zero ? (funct3[1] ? op_a : '1)
                                    : (funct3[1] ? ZERO : op_a);

  // One multiply step: conditional add into the high half, then shift right.
  logic [DATA_W:0]     w_sum;
  logic [2*DATA_W-1:0] w_mul_next;
  assign w_sum      = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
                      (r_acc[0] ? {1'b0, r_addend} : {1'b0, ZERO});
  assign w_mul_next = {w_sum, r_acc[DATA_W-1:1]};

  // One restoring-divide step: shift left, trial-subtract the divisor.
  logic [DATA_W:0]     w_rem_wide, w_trial;
  logic [2*DATA_W-1:0] w_div_next;
  assign w_rem_wide = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_trial    = w_rem_wide - {1'b0, r_addend};
  assign w_div_next = w_trial[DATA_W]
                    ? {w_rem_wide[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                    : {w_trial[DATA_W-1:0],    r_acc[DATA_W-2:0], 1'b1};

  // Sign fix-up and result selection
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot, w_rem, w_fix_result;
  assign w_prod = r_neg_res ? (ZERO2 - r_acc) : r_acc;
  assign w_quot = r_neg_res ? (ZERO - r_acc[DATA_W-1:0]) : r_acc[DATA_W-1:0];
  assign w_rem  = r_neg_rem ? (ZERO - r_acc[2*DATA_W-1:DATA_W]) : r_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_fix_result = w_rem;
    case (r_funct3)
      F3_MUL:                       w_fix_result = w_prod[DATA_W-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fix_result = w_prod[2*DATA_W-1:DATA_W];
      F3_DIV, F3_DIVU:              w_fix_result = w_quot;
      default:                      w_fix_result = w_rem;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM: next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!flush && start) w_next = w_fast ? S_DONE : S_CALC;
      S_CALC: if (flush) w_next = S_IDLE;
              else if (r_cnt == CNT_LAST) w_next = S_FIX;
      S_FIX:  w_next = flush ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  assign result = r_result;

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_funct3  <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_addend  <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start && !flush) begin
          r_funct3  <= funct3;
          r_neg_res <= w_a_neg ^ w_b_neg;
          r_neg_rem <= w_a_neg;
          r_addend  <= w_is_div ? w_mag_b : w_mag_a;
          r_acc     <= {ZERO, (w_is_div ? w_mag_a : w_mag_b)};
          r_cnt     <= '0;
          if (w_fast) r_result <= w_fast_result;
        end
        S_CALC: begin
          r_acc <= r_funct3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + CNT_ONE;
        end
        // Result is loaded on the edge into DONE so it is valid with done.
        S_FIX: if (!flush) r_result <= w_fix_result;
        default: ;
      endcase
    end
  end

endmodule
